// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
// Multi-cycle HI/LO unit for MULT/MULTU/DIV/DIVU. It uses a shift-add
// multiplier and a restoring divider, one step per cycle over WIDTH cycles,
// and owns the architectural HI/LO registers.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, op, a, b   issue an operation: op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   mthi, mtlo, wdata direct HI/LO writes (only honoured while idle)
//   rd_hilo           MFHI/MFLO in EX this cycle (only affects stall)
//   hi, lo            committed HI/LO values
//   busy              operation in flight (registered)
//   done              one-cycle pulse after the HI/LO update
//   stall             pipeline stall request (combinational)
module mult_div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_hilo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

   state_t             state_reg, state_next;
   logic [1:0]         op_reg;          // [0] signed, [1] divide
   logic [WIDTH-1:0]   a_reg, b_reg;    // raw operands, then magnitudes after PREP
   logic               sign_q_reg, sign_r_reg;
   logic [2*WIDTH-1:0] acc_reg;         // mult: {partial, multiplier}; div: {remainder, quotient}
   logic [CW-1:0]      count_reg;

   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     shifted, trial;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   // Magnitudes: the most negative value maps onto itself, which is its
   // correct unsigned magnitude.
   assign a_abs = (op_reg[0] && a_reg[WIDTH-1]) ? -a_reg : a_reg;
   assign b_abs = (op_reg[0] && b_reg[WIDTH-1]) ? -b_reg : b_reg;

   // Shift-add step: conditionally add the multiplicand into the upper half
   // (keeping the carry), then shift the whole register right by one.
   assign add_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
   assign mul_next = {add_sum, acc_reg[WIDTH-1:1]};

   // Restoring step: bring the next dividend bit into the remainder and keep
   // the trial difference only when it did not borrow. A zero divisor always
   // "succeeds", yielding an all-ones quotient and remainder = dividend.
   assign shifted  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
   assign trial    = shifted - {1'b0, b_reg};
   assign div_next = trial[WIDTH] ? {shifted[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0],   acc_reg[WIDTH-2:0], 1'b1};

   assign prod_fix = sign_q_reg ? -acc_reg : acc_reg;
   assign quot_fix = sign_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
   assign rem_fix  = sign_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

   assign stall = busy & (start | rd_hilo | mthi | mtlo);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = PREP;
         PREP:    state_next = CALC;
         CALC:    if (count_reg == LAST) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         sign_q_reg <= 1'b0;
         sign_r_reg <= 1'b0;
         acc_reg    <= '0;
         count_reg  <= '0;
         hi         <= '0;
         lo         <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_next != IDLE);
         done <= (state_reg == FIX);
         case (state_reg)
            IDLE: begin
               if (start) begin
                  // A simultaneous MTHI/MTLO is dropped in favour of the op.
                  op_reg <= op;
                  a_reg  <= a;
                  b_reg  <= b;
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            PREP: begin
               a_reg      <= a_abs;
               b_reg      <= b_abs;
               sign_q_reg <= op_reg[0] & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
               sign_r_reg <= op_reg[0] & a_reg[WIDTH-1];
               acc_reg    <= op_reg[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
               count_reg  <= '0;
            end
            CALC: begin
               acc_reg   <= op_reg[1] ? div_next : mul_next;
               count_reg <= count_reg + 1'b1;
            end
            FIX: begin
               if (op_reg[1]) begin
                  lo <= quot_fix;
                  hi <= rem_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
